fwd_regfile: RTL and testbench
==============================

# fwd_regfile

Parametrised general-purpose register file for the openMIPS core with built-in operand forwarding, load-use hazard detection and a pending-write scoreboard for multi-cycle results. It replaces the fixed two-port regfile plus ad-hoc ID-stage bypass muxes. It sits in the ID stage, reads operands for the decoder, and receives write-back data from the EX, MEM and WB stages. It drives the stall request into the pipeline controller and keeps a stall-cycle performance counter.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width (2**ADDR_W registers, register 0 hard-wired to zero)
- NREAD, 2, number of read ports
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  forwarded operand per port, same packing
- ex_we, ex_waddr, ex_wdata, ex_is_load  in  1/ADDR_W/DATA_W/1  EX-stage result and load flag
- mem_we, mem_waddr, mem_wdata  in  1/ADDR_W/DATA_W  MEM-stage result
- wb_we, wb_waddr, wb_wdata  in  1/ADDR_W/DATA_W  WB write port
- mc_start, mc_waddr  in  1/ADDR_W  multi-cycle op (mult/div) issued, marks destination pending
- mc_done  in  1  multi-cycle result is on the WB port this cycle; clears pending bit of wb_waddr
- stall_req  out  1  hold IF/ID, insert bubble
- mc_busy  out  1  a multi-cycle op is outstanding
- stall_cnt  out  CNT_W  cycles with stall_req high since reset

## Operation
- Read port i, combinational: re[i]=0 or raddr=0 -> 0; else first match in priority EX (ex_we, not ex_is_load) > MEM > WB > array.
- EX match with ex_is_load=1 supplies no data; falls through to MEM/WB/array (value irrelevant, stall asserted).
- Load-use: stall_req=1 if ex_we & ex_is_load & ex_waddr!=0 and any enabled port reads ex_waddr.
- Scoreboard: one pending bit per register. mc_start sets pending[mc_waddr] (ignored for address 0). mc_done & wb_we clears pending[wb_waddr]. Any enabled read of a pending register -> stall_req=1.
- mc_busy = OR of pending bits. mc_start while mc_busy is accepted (second outstanding op); no limit besides one bit per register.
- mc_start and mc_done on the same register same cycle: set wins (new op outstanding).
- Array write at posedge when wb_we & wb_waddr!=0. Register 0 never written.
- stall_cnt increments each cycle stall_req=1, saturates at all-ones.

## Timing
- Reset (rst=0 at posedge): all registers 0, all pending bits 0, stall_cnt 0. Outputs after reset: rdata 0 (array empty), stall_req 0 unless load-use inputs active, mc_busy 0.
- rdata and stall_req are combinational in the same cycle as raddr; zero latency through forwarding.
- WB write visible on rdata same cycle via bypass, in array from next cycle.
- Pending set by mc_start is visible to stall_req the following cycle; the op-issuing cycle itself does not self-stall.
- Pending clear on mc_done: same-cycle read of that register gets WB data via bypass and does not stall (clear is forwarded combinationally).
- Reset mid-operation discards pending bits; later mc_done with nothing pending is harmless.

## Structure
- Shared package/header: DATA_W/ADDR_W defaults, zero-register constant, opcode-independent defines only.
- One sub-module: fwd_mux (single read port: priority select and hazard match), instantiated NREAD times by generate; top holds array, scoreboard, counter and stall OR-reduction.

## Test plan
- Back-to-back ori chain ($1=0x1100, $1|=0x0020, $1|=0x4400, $1|=0x0044): EX/MEM/WB forwarding gives reads 0x1100, 0x1120, 0x5520, 0x5564 with no stall.
- Same-address EX and MEM both writing $3 (0xAAAA / 0xBBBB): port reads 0xAAAA (EX priority).
- Load to $4 in EX, port 1 reads $4 -> stall_req=1 for one cycle, stall_cnt 0->1; next cycle MEM supplies data, stall_req=0.
- mc_start to $5, read $5 for 3 cycles -> stall_req=1, mc_busy=1; mc_done with wb_wdata=0x12345678 -> read returns 0x12345678 same cycle, stall_req=0, mc_busy=0 next cycle.
- Writes to $0 from all sources with 0xFFFFFFFF -> reads of $0 return 0, no stall.
- rst=0 asserted with $5 pending and registers written -> all reads 0, mc_busy=0, stall_cnt=0 after the reset edge.

Source files
------------

// File: rtl/fwd_regfile_pkg.sv
// rtl/fwd_regfile_pkg.sv - shared widths and constants for the forwarding register file
package fwd_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    // Register 0 reads as zero, is never written and never goes pending
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/fwd_regfile_fwd_mux.sv
// rtl/fwd_regfile_fwd_mux.sv - one read port: forwarding priority select and hazard match
module fwd_mux
    import fwd_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] arr_rdata,
    input  logic              pend_hit,
    output logic [DATA_W-1:0] rdata,
    output logic              hazard
);

    logic rd_en;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Youngest producer wins; a load in EX has no data yet, so it is skipped and only raises a hazard
    always_comb begin
        rd_en   = re && (raddr != ADDR_W'(ZERO_REG));
        ex_hit  = ex_we && (ex_waddr == raddr);
        mem_hit = mem_we && (mem_waddr == raddr);
        wb_hit  = wb_we && (wb_waddr == raddr);
        rdata   = '0;
        if (rd_en) begin
            if (ex_hit && !ex_is_load) begin
                rdata = ex_wdata;
            end else if (mem_hit) begin
                rdata = mem_wdata;
            end else if (wb_hit) begin
                rdata = wb_wdata;
            end else begin
                rdata = arr_rdata;
            end
        end
        hazard = rd_en && ((ex_hit && ex_is_load) || pend_hit);
    end

endmodule

// File: rtl/fwd_regfile.sv
// rtl/fwd_regfile.sv - register array, multi-cycle scoreboard, stall counter and per-port forwarding
module fwd_regfile
    import fwd_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    input  logic                     ex_we,
    input  logic [ADDR_W-1:0]        ex_waddr,
    input  logic [DATA_W-1:0]        ex_wdata,
    input  logic                     ex_is_load,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_wdata,
    input  logic                     mc_start,
    input  logic [ADDR_W-1:0]        mc_waddr,
    input  logic                     mc_done,
    output logic                     stall_req,
    output logic                     mc_busy,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [NREAD-1:0]  hazard;
    logic              mc_clear;

    assign mc_clear = mc_done && wb_we;

    genvar g;
    generate
        for (g = 0; g < NREAD; g++) begin : g_port
            logic [ADDR_W-1:0] port_addr;
            logic              port_pend;

            assign port_addr = raddr[g*ADDR_W +: ADDR_W];
            // A completing op clears its pending bit for same-cycle readers too
            assign port_pend = pending_q[port_addr] && !(mc_clear && (wb_waddr == port_addr));

            fwd_mux #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_fwd_mux (
                .re         (re[g]),
                .raddr      (port_addr),
                .ex_we      (ex_we),
                .ex_waddr   (ex_waddr),
                .ex_wdata   (ex_wdata),
                .ex_is_load (ex_is_load),
                .mem_we     (mem_we),
                .mem_waddr  (mem_waddr),
                .mem_wdata  (mem_wdata),
                .wb_we      (wb_we),
                .wb_waddr   (wb_waddr),
                .wb_wdata   (wb_wdata),
                .arr_rdata  (regs_q[port_addr]),
                .pend_hit   (port_pend),
                .rdata      (rdata[g*DATA_W +: DATA_W]),
                .hazard     (hazard[g])
            );
        end
    endgenerate

    assign stall_req = |hazard;
    assign mc_busy   = |pending_q;
    assign stall_cnt = stall_cnt_q;

    // WB port writes the array; register 0 stays zero
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_waddr != ADDR_W'(ZERO_REG))) begin
            regs_d[wb_waddr] = wb_wdata;
        end
    end

    // Completion clears first so an issue to the same register in the same cycle stays pending
    always_comb begin
        pending_d = pending_q;
        if (mc_clear) begin
            pending_d[wb_waddr] = 1'b0;
        end
        if (mc_start && (mc_waddr != ADDR_W'(ZERO_REG))) begin
            pending_d[mc_waddr] = 1'b1;
        end
    end

    // Stall cycle counter holds at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_req && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_regfile.sv
// tb/tb_fwd_regfile.sv - randomized and directed self-checking bench for fwd_regfile
module tb_fwd_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ex_we, ex_is_load, mem_we, wb_we;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr, mc_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        mc_start, mc_done;
    logic        stall_req, mc_busy;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          m_cnt;

    always #5 clk = ~clk;

    fwd_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .ex_we      (ex_we),
        .ex_waddr   (ex_waddr),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .mc_start   (mc_start),
        .mc_waddr   (mc_waddr),
        .mc_done    (mc_done),
        .stall_req  (stall_req),
        .mc_busy    (mc_busy),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] port_addr(input int p);
        logic [9:0] v;
        v = raddr;
        return v[p*5 +: 5];
    endfunction

    // Operand value: nearest older instruction that writes the register, else the array
    function automatic logic [31:0] exp_rd(input int p);
        logic [4:0] a;
        a = port_addr(p);
        if (!re[p] || a == 5'd0) return 32'd0;
        if (ex_we && !ex_is_load && ex_waddr == a) return ex_wdata;
        if (mem_we && mem_waddr == a) return mem_wdata;
        if (wb_we && wb_waddr == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall();
        bit s;
        logic [4:0] a;
        s = 0;
        for (int p = 0; p < 2; p++) begin
            a = port_addr(p);
            if (re[p] && a != 5'd0) begin
                if (ex_we && ex_is_load && ex_waddr == a) s = 1;
                if (m_pend[a] && !(mc_done && wb_we && wb_waddr == a)) s = 1;
            end
        end
        return s;
    endfunction

    function automatic bit exp_busy();
        bit b;
        b = 0;
        for (int r = 0; r < 32; r++) b = b | m_pend[r];
        return b;
    endfunction

    task automatic compare();
        chk("rdata0", rdata[31:0], exp_rd(0));
        chk("rdata1", rdata[63:32], exp_rd(1));
        chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall()});
        chk("mc_busy", {31'd0, mc_busy}, {31'd0, exp_busy()});
        chk("stall_cnt", {16'd0, stall_cnt}, m_cnt[31:0]);
    endtask

    task automatic model_update();
        bit s;
        s = exp_stall();
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'd0;
                m_pend[r] = 0;
            end
            m_cnt = 0;
        end else begin
            if (wb_we && wb_waddr != 5'd0) m_regs[wb_waddr] = wb_wdata;
            if (mc_done && wb_we) m_pend[wb_waddr] = 0;
            if (mc_start && mc_waddr != 5'd0) m_pend[mc_waddr] = 1;
            if (s && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        re = 2'b00; raddr = '0;
        ex_we = 0; ex_waddr = '0; ex_wdata = '0; ex_is_load = 0;
        mem_we = 0; mem_waddr = '0; mem_wdata = '0;
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        mc_start = 0; mc_waddr = '0; mc_done = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        re = 2'b11;
        raddr = {a1, a0};
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_update();
        #1;
        rst = 1'b1;

        // Reset state
        rd(5'd1, 5'd7);
        settle();
        chk("reset_rdata0", rdata[31:0], 32'h0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        chk("reset_busy", {31'd0, mc_busy}, 32'd0);
        chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        advance();

        // ori chain on $1 through EX, MEM, WB
        idle(); rd(5'd1, 5'd0);
        ex_we = 1; ex_waddr = 5'd1; ex_wdata = 32'h1100;
        settle(); chk("ori1", rdata[31:0], 32'h1100); advance();
        ex_wdata = 32'h1120; mem_we = 1; mem_waddr = 5'd1; mem_wdata = 32'h1100;
        settle(); chk("ori2", rdata[31:0], 32'h1120); advance();
        ex_wdata = 32'h5520; mem_wdata = 32'h1120; wb_we = 1; wb_waddr = 5'd1; wb_wdata = 32'h1100;
        settle(); chk("ori3", rdata[31:0], 32'h5520); advance();
        ex_wdata = 32'h5564; mem_wdata = 32'h5520; wb_wdata = 32'h1120;
        settle(); chk("ori4", rdata[31:0], 32'h5564);
        chk("ori_nostall", {31'd0, stall_req}, 32'd0); advance();
        idle(); rd(5'd0, 5'd1);
        settle(); chk("ori_array", rdata[63:32], 32'h1120); advance();

        // EX beats MEM for the same destination
        idle(); rd(5'd3, 5'd3);
        ex_we = 1; ex_waddr = 5'd3; ex_wdata = 32'hAAAA;
        mem_we = 1; mem_waddr = 5'd3; mem_wdata = 32'hBBBB;
        settle(); chk("ex_prio", rdata[31:0], 32'hAAAA); advance();

        // Load-use on $4
        idle(); re = 2'b10; raddr = {5'd4, 5'd0};
        ex_we = 1; ex_waddr = 5'd4; ex_wdata = 32'hDEAD; ex_is_load = 1;
        settle(); chk("load_stall", {31'd0, stall_req}, 32'd1);
        chk("load_cnt0", {16'd0, stall_cnt}, 32'd0); advance();
        idle(); re = 2'b10; raddr = {5'd4, 5'd0};
        mem_we = 1; mem_waddr = 5'd4; mem_wdata = 32'hCAFE;
        settle(); chk("load_mem", rdata[63:32], 32'hCAFE);
        chk("load_nostall", {31'd0, stall_req}, 32'd0);
        chk("load_cnt1", {16'd0, stall_cnt}, 32'd1); advance();

        // Multi-cycle op to $5
        idle(); rd(5'd5, 5'd0); mc_start = 1; mc_waddr = 5'd5;
        settle(); chk("mc_issue_nostall", {31'd0, stall_req}, 32'd0); advance();
        idle(); rd(5'd5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mc_stall", {31'd0, stall_req}, 32'd1);
            chk("mc_busy", {31'd0, mc_busy}, 32'd1);
            advance();
        end
        mc_done = 1; wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'h12345678;
        settle(); chk("mc_done_data", rdata[31:0], 32'h12345678);
        chk("mc_done_nostall", {31'd0, stall_req}, 32'd0); advance();
        idle(); rd(5'd5, 5'd0);
        settle(); chk("mc_idle", {31'd0, mc_busy}, 32'd0);
        chk("mc_cnt", {16'd0, stall_cnt}, 32'd4); advance();

        // Register 0 ignores every writer
        idle(); rd(5'd0, 5'd0);
        ex_we = 1; ex_wdata = 32'hFFFFFFFF;
        mem_we = 1; mem_wdata = 32'hFFFFFFFF;
        wb_we = 1; wb_wdata = 32'hFFFFFFFF;
        mc_start = 1;
        settle(); chk("zero_rd", rdata[31:0], 32'h0);
        chk("zero_nostall", {31'd0, stall_req}, 32'd0); advance();
        idle(); rd(5'd0, 5'd0);
        settle(); chk("zero_busy", {31'd0, mc_busy}, 32'd0); advance();

        // Randomized traffic over a small address window
        for (int c = 0; c < 400; c++) begin
            re = 2'($urandom);
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_we = 1'($urandom); ex_waddr = 5'($urandom_range(0, 7));
            ex_wdata = $urandom; ex_is_load = ($urandom_range(0, 3) == 0);
            mem_we = 1'($urandom); mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
            wb_we = 1'($urandom); wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
            mc_start = ($urandom_range(0, 7) == 0); mc_waddr = 5'($urandom_range(0, 7));
            mc_done = ($urandom_range(0, 3) == 0);
            settle();
            advance();
        end

        // Reset with $5 pending and registers populated
        idle(); wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'h77;
        mc_start = 1; mc_waddr = 5'd5;
        settle(); advance();
        idle(); rd(5'd5, 5'd2); rst = 1'b0;
        settle(); advance();
        rst = 1'b1; idle(); rd(5'd5, 5'd2);
        settle(); chk("rst_rd0", rdata[31:0], 32'h0);
        chk("rst_rd1", rdata[63:32], 32'h0);
        chk("rst_busy", {31'd0, mc_busy}, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_nostall", {31'd0, stall_req}, 32'd0); advance();
        idle(); rd(5'd5, 5'd0); mc_done = 1; wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'h9;
        settle(); chk("late_done", rdata[31:0], 32'h9); advance();
        idle();
        settle(); chk("late_done_busy", {31'd0, mc_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
